// File: rtl/dm_dma_arbiter_pkg.sv
// Shared types for the DM port arbiter: transfer FSM states, DMA direction
// codes and the starvation counter width.
package dm_dma_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dma_state_e;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    // Wide enough for STARVE_LIMIT up to 15.
    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/dm_dma_arbiter_if.sv
// Data-memory port as seen by the memory block: the arbiter drives the
// request side (master), the memory returns read data (slave).
interface dm_dma_arbiter_if #(
    parameter int unsigned DMA_SIZE = 16,
    parameter int unsigned DMD_SIZE = 16
);

    logic                arb_dm_cslt;
    logic                arb_dm_wrb;
    logic [DMA_SIZE-1:0] arb_dm_add;
    logic [DMD_SIZE-1:0] arb_dm_wdt;
    logic [DMD_SIZE-1:0] dm_arb_rdt;

    modport master (
        output arb_dm_cslt,
        output arb_dm_wrb,
        output arb_dm_add,
        output arb_dm_wdt,
        input  dm_arb_rdt
    );

    modport slave (
        input  arb_dm_cslt,
        input  arb_dm_wrb,
        input  arb_dm_add,
        input  arb_dm_wdt,
        output dm_arb_rdt
    );

endinterface

// File: rtl/dm_dma_arbiter_starve.sv
// Counts consecutive transfer cycles in which the core took the DM port and
// raises force_q for one cycle once the limit is reached.
module dm_starve_ctr
    import dm_dma_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic core_win,
    input  logic dma_slot,
    output logic force_q
);

    localparam logic [STARVE_CNT_W:0] LIMIT_V = (STARVE_CNT_W+1)'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [STARVE_CNT_W:0]   cnt_inc;

    assign cnt_inc = {1'b0, starve_cnt} + 1'b1;

    // force_q is raised on the same edge the count reaches the limit, so the
    // forced slot follows exactly STARVE_LIMIT denied cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
            force_q    <= 1'b0;
        end else if (!run || dma_slot) begin
            starve_cnt <= '0;
            force_q    <= 1'b0;
        end else if (core_win) begin
            if (starve_cnt != '1) begin
                starve_cnt <= cnt_inc[STARVE_CNT_W-1:0];
            end
            force_q <= (cnt_inc >= LIMIT_V);
        end
    end

endmodule

// File: rtl/dm_dma_arbiter.sv
// Shares the single DM port between the core (always preferred) and a block
// DMA channel that uses idle cycles plus periodic forced slots.
module dm_dma_arbiter
    import dm_dma_arbiter_pkg::*;
#(
    parameter int unsigned DMA_SIZE     = 16,
    parameter int unsigned DMD_SIZE     = 16,
    parameter int unsigned LEN_WIDTH    = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps_dm_cslt,
    input  logic                 ps_dm_wrb,
    input  logic [DMA_SIZE-1:0]  dg_dm_add,
    input  logic [DMD_SIZE-1:0]  bc_dt_out,
    output logic                 ps_stall,
    input  logic                 dma_start,
    input  logic                 dma_dir,
    input  logic [DMA_SIZE-1:0]  dma_base,
    input  logic [LEN_WIDTH-1:0] dma_len,
    input  logic [DMD_SIZE-1:0]  dma_wdt,
    output logic                 dma_wr_ack,
    output logic                 dma_rd_valid,
    output logic [DMD_SIZE-1:0]  dma_rdt,
    output logic                 dma_busy,
    output logic                 dma_done,
    dm_dma_arbiter_if.master     mem
);

    dma_state_e           state_q, state_d;
    logic [DMA_SIZE-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 dir_q, dir_d;
    logic                 rd_valid_q;
    logic                 force_q;
    logic                 run;
    logic                 dma_slot;
    logic                 core_win;

    assign run      = (state_q == ST_RUN);
    assign dma_slot = run && (force_q || !ps_dm_cslt);
    assign core_win = ps_dm_cslt && !dma_slot;

    dm_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .core_win (core_win),
        .dma_slot (dma_slot),
        .force_q  (force_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            dir_q      <= DIR_RD;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            dir_q      <= dir_d;
            rd_valid_q <= dma_slot && (dir_q == DIR_RD);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dma_start) begin
                    addr_d  = dma_base;
                    rem_d   = dma_len;
                    dir_d   = dma_dir;
                    state_d = (dma_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (dma_slot) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem.arb_dm_cslt = 1'b0;
        mem.arb_dm_wrb  = 1'b0;
        mem.arb_dm_add  = '0;
        mem.arb_dm_wdt  = '0;
        dma_wr_ack      = 1'b0;
        if (dma_slot) begin
            mem.arb_dm_cslt = 1'b1;
            mem.arb_dm_wrb  = dir_q;
            mem.arb_dm_add  = addr_q;
            if (dir_q == DIR_WR) begin
                mem.arb_dm_wdt = dma_wdt;
                dma_wr_ack     = 1'b1;
            end
        end else if (ps_dm_cslt) begin
            mem.arb_dm_cslt = 1'b1;
            mem.arb_dm_wrb  = ps_dm_wrb;
            mem.arb_dm_add  = dg_dm_add;
            mem.arb_dm_wdt  = bc_dt_out;
        end
    end

    assign ps_stall     = force_q;
    assign dma_rd_valid = rd_valid_q;
    assign dma_rdt      = rd_valid_q ? mem.dm_arb_rdt : '0;
    assign dma_busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign dma_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_dm_dma_arbiter.sv
// Self-checking bench for dm_dma_arbiter: directed scenarios plus a random
// run, all compared cycle by cycle against a transfer-level reference model.
module tb_dm_dma_arbiter;
    import dm_dma_arbiter_pkg::*;

    localparam int unsigned LIMIT = 4;
    localparam logic [15:0] KEY   = 16'h5A3C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ps_dm_cslt = 1'b0;
    logic        ps_dm_wrb = 1'b0;
    logic [15:0] dg_dm_add = '0;
    logic [15:0] bc_dt_out = '0;
    logic        ps_stall;
    logic        dma_start = 1'b0;
    logic        dma_dir = 1'b0;
    logic [15:0] dma_base = '0;
    logic [7:0]  dma_len = '0;
    logic [15:0] dma_wdt = '0;
    logic        dma_wr_ack;
    logic        dma_rd_valid;
    logic [15:0] dma_rdt;
    logic        dma_busy;
    logic        dma_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_dma_arbiter_if #(.DMA_SIZE(16), .DMD_SIZE(16)) mem_if ();

    dm_dma_arbiter #(
        .DMA_SIZE(16), .DMD_SIZE(16), .LEN_WIDTH(8), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb),
        .dg_dm_add(dg_dm_add), .bc_dt_out(bc_dt_out), .ps_stall(ps_stall),
        .dma_start(dma_start), .dma_dir(dma_dir), .dma_base(dma_base),
        .dma_len(dma_len), .dma_wdt(dma_wdt), .dma_wr_ack(dma_wr_ack),
        .dma_rd_valid(dma_rd_valid), .dma_rdt(dma_rdt),
        .dma_busy(dma_busy), .dma_done(dma_done),
        .mem(mem_if)
    );

    // Memory stand-in: read data is a fixed function of the last read address.
    logic [15:0] rd_addr_q = '0;
    always @(posedge clk)
        if (mem_if.arb_dm_cslt && !mem_if.arb_dm_wrb) rd_addr_q <= mem_if.arb_dm_add;
    assign mem_if.dm_arb_rdt = rd_addr_q ^ KEY;

    // Reference model: words still owed, next address, denied-cycle count.
    int          m_left = 0;
    logic [15:0] m_addr = '0;
    logic        m_dir = 1'b0;
    logic        m_done = 1'b0;
    int          m_denied = 0;
    logic        m_force = 1'b0;
    logic        m_rdp = 1'b0;
    logic [15:0] m_rda = '0;

    logic [54:0] exp_vec, obs_vec;
    logic        last_stall = 1'b0;
    logic        o_cslt, o_wrb, o_ack, o_rdv, o_done, o_stall;
    logic [15:0] o_add, o_rdt;

    task automatic drive_cycle();
        logic        run, owns, e_cslt, e_wrb, e_ack, nd;
        logic [15:0] e_add, e_wdt, e_rdt;
        @(negedge clk);
        run    = (m_left > 0);
        owns   = run && (m_force || !ps_dm_cslt);
        e_cslt = 1'b0; e_wrb = 1'b0; e_add = '0; e_wdt = '0; e_ack = 1'b0;
        if (owns) begin
            e_cslt = 1'b1; e_wrb = m_dir; e_add = m_addr;
            e_wdt  = m_dir ? dma_wdt : 16'h0; e_ack = m_dir;
        end else if (ps_dm_cslt) begin
            e_cslt = 1'b1; e_wrb = ps_dm_wrb; e_add = dg_dm_add; e_wdt = bc_dt_out;
        end
        e_rdt   = m_rdp ? (m_rda ^ KEY) : 16'h0;
        exp_vec = {m_force, e_cslt, e_wrb, e_add, e_wdt, e_ack, m_rdp, e_rdt,
                   (run || m_done), m_done};
        obs_vec = {ps_stall, mem_if.arb_dm_cslt, mem_if.arb_dm_wrb, mem_if.arb_dm_add,
                   mem_if.arb_dm_wdt, dma_wr_ack, dma_rd_valid, dma_rdt, dma_busy, dma_done};
        o_cslt = mem_if.arb_dm_cslt; o_wrb = mem_if.arb_dm_wrb; o_add = mem_if.arb_dm_add;
        o_ack = dma_wr_ack; o_rdv = dma_rd_valid; o_rdt = dma_rdt;
        o_done = dma_done; o_stall = ps_stall;
        last_stall = m_force;
        @(posedge clk);
        if (!reset) begin
            m_left = 0; m_done = 1'b0; m_denied = 0; m_force = 1'b0; m_rdp = 1'b0;
        end else begin
            m_rdp = owns && !m_dir;
            m_rda = m_addr;
            nd = 1'b0;
            if (run) begin
                if (owns) begin
                    m_addr = m_addr + 16'd1; m_left = m_left - 1;
                    nd = (m_left == 0); m_denied = 0; m_force = 1'b0;
                end else begin
                    m_denied = m_denied + 1; m_force = (m_denied >= LIMIT);
                end
            end else begin
                m_denied = 0; m_force = 1'b0;
                if (!m_done && dma_start) begin
                    m_addr = dma_base; m_left = int'(dma_len); m_dir = dma_dir;
                    nd = (dma_len == 8'd0);
                end
            end
            m_done = nd;
        end
        #1;
        if (e_ack) dma_wdt = 16'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_cycle();
        drive_cycle();
        checks++;
        if (obs_vec !== 55'h0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0", obs_vec);
        end
        reset = 1'b1;
    endtask

    task automatic test_dma_write();
        int acks = 0, dones = 0, done_cyc = -1;
        logic [15:0] seen[$];
        dma_dir = DIR_WR; dma_base = 16'h0010; dma_len = 8'd4; dma_wdt = 16'($urandom);
        for (int c = 0; c < 8; c++) begin
            dma_start = (c == 0);
            drive_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL dma_write cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (o_ack) begin acks++; seen.push_back(o_add); end
            if (o_done) begin dones++; done_cyc = c; end
        end
        checks++;
        if (acks != 4 || dones != 1 || done_cyc != 5) begin
            failures++; $display("FAIL write_counts acks=%0d dones=%0d done_cyc=%0d want 4/1/5", acks, dones, done_cyc);
        end
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            checks++;
            if (seen[i] !== 16'h0010 + 16'(i)) begin
                failures++; $display("FAIL write_addr%0d got=%h want=%h", i, seen[i], 16'h0010 + 16'(i));
            end
        end
    endtask

    task automatic test_dma_read();
        logic [15:0] exp_a [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        logic [15:0] seen[$];
        int rdv = 0;
        logic done_rdv = 1'b0;
        logic [15:0] done_rdt = '0;
        dma_dir = DIR_RD; dma_base = 16'hFFFE; dma_len = 8'd3;
        for (int c = 0; c < 7; c++) begin
            dma_start = (c == 0);
            drive_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL dma_read cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (o_cslt) seen.push_back(o_add);
            if (o_rdv) rdv++;
            if (o_done) begin done_rdv = o_rdv; done_rdt = o_rdt; end
        end
        checks++;
        if (seen.size() != 3 || rdv != 3) begin
            failures++; $display("FAIL read_counts slots=%0d valids=%0d want 3/3", seen.size(), rdv);
        end
        for (int i = 0; i < seen.size() && i < 3; i++) begin
            checks++;
            if (seen[i] !== exp_a[i]) begin
                failures++; $display("FAIL read_addr%0d got=%h want=%h", i, seen[i], exp_a[i]);
            end
        end
        checks++;
        if (done_rdv !== 1'b1 || done_rdt !== 16'h5A3C) begin
            failures++; $display("FAIL read_last_with_done valid=%b rdt=%h want 1/5a3c", done_rdv, done_rdt);
        end
    endtask

    task automatic test_starvation();
        int stalls = 0;
        int stall_cyc[$];
        logic [15:0] held = '0;
        logic chk_held = 1'b0;
        dma_dir = DIR_WR; dma_base = 16'h0400; dma_len = 8'd2;
        for (int c = 0; c < 14; c++) begin
            dma_start = (c == 0);
            if (!last_stall) begin
                ps_dm_cslt = 1'b1; ps_dm_wrb = 1'($urandom);
                dg_dm_add = 16'($urandom); bc_dt_out = 16'($urandom);
            end
            drive_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL starve cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (chk_held) begin
                checks++;
                if (o_add !== held || o_cslt !== 1'b1) begin
                    failures++; $display("FAIL starve_held cyc=%0d got=%h want=%h", c, o_add, held);
                end
            end
            chk_held = o_stall;
            if (o_stall) begin stalls++; stall_cyc.push_back(c); held = dg_dm_add; end
        end
        ps_dm_cslt = 1'b0;
        checks++;
        if (stalls != 2 || stall_cyc.size() != 2 || stall_cyc[0] != 5 || stall_cyc[1] != 10) begin
            failures++; $display("FAIL starve_stalls count=%0d want 2 at cycles 5,10", stalls);
        end
    endtask

    task automatic test_alternate();
        int stalls = 0, acks = 0, dones = 0;
        dma_dir = DIR_WR; dma_base = 16'h0700; dma_len = 8'd6;
        for (int c = 0; c < 16; c++) begin
            dma_start = (c == 0);
            ps_dm_cslt = c[0]; ps_dm_wrb = 1'($urandom);
            dg_dm_add = 16'($urandom); bc_dt_out = 16'($urandom);
            drive_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL alternate cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (o_stall) stalls++;
            if (o_ack) acks++;
            if (o_done) dones++;
        end
        ps_dm_cslt = 1'b0;
        checks++;
        if (stalls != 0 || acks != 6 || dones != 1) begin
            failures++; $display("FAIL alternate_counts stalls=%0d acks=%0d dones=%0d want 0/6/1", stalls, acks, dones);
        end
    endtask

    task automatic test_zero_len();
        int slots = 0, done_cyc = -1;
        dma_dir = DIR_WR; dma_base = 16'h1234; dma_len = 8'd0;
        for (int c = 0; c < 4; c++) begin
            dma_start = (c == 0);
            drive_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL zero_len cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (o_cslt) slots++;
            if (o_done) done_cyc = c;
        end
        checks++;
        if (slots != 0 || done_cyc != 1) begin
            failures++; $display("FAIL zero_len_result slots=%0d done_cyc=%0d want 0/1", slots, done_cyc);
        end
    endtask

    task automatic test_start_ignored();
        int writes = 0, done_cyc = -1;
        logic [15:0] seen[$];
        for (int c = 0; c < 9; c++) begin
            dma_start = (c == 0) || (c == 2);
            dma_dir   = (c == 2) ? DIR_WR : DIR_RD;
            dma_base  = (c == 2) ? 16'h8000 : 16'h0100;
            dma_len   = (c == 2) ? 8'd1 : 8'd5;
            drive_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL start_ignored cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (o_cslt) seen.push_back(o_add);
            if (o_cslt && o_wrb) writes++;
            if (o_done) done_cyc = c;
        end
        dma_start = 1'b0;
        checks++;
        if (seen.size() != 5 || writes != 0 || done_cyc != 6) begin
            failures++; $display("FAIL start_ignored_result slots=%0d writes=%0d done_cyc=%0d want 5/0/6", seen.size(), writes, done_cyc);
        end
        for (int i = 0; i < seen.size() && i < 5; i++) begin
            checks++;
            if (seen[i] !== 16'h0100 + 16'(i)) begin
                failures++; $display("FAIL start_ignored_addr%0d got=%h want=%h", i, seen[i], 16'h0100 + 16'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        dma_dir = DIR_WR; dma_base = 16'h0200; dma_len = 8'd8;
        for (int c = 0; c < 10; c++) begin
            dma_start = (c == 0);
            reset = (c != 4);
            drive_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL reset_mid cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (c == 5) begin
                checks++;
                if (obs_vec !== 55'h0) begin
                    failures++; $display("FAIL reset_mid_clear got=%h want=0", obs_vec);
                end
            end
            if (o_done) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++; $display("FAIL reset_mid_done got=%0d want=0", dones);
        end
        dma_base = 16'h0300; dma_len = 8'd2;
        for (int c = 0; c < 5; c++) begin
            dma_start = (c == 0);
            drive_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL reset_restart cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (o_done) dones++;
        end
        checks++;
        if (dones != 1) begin
            failures++; $display("FAIL reset_restart_done got=%0d want=1", dones);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            dma_start = (c < 370) && ($urandom_range(0, 4) == 0);
            dma_dir   = 1'($urandom);
            dma_base  = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom);
            dma_len   = 8'($urandom_range(0, 6));
            if (!last_stall) begin
                ps_dm_cslt = (c < 370) && ($urandom_range(0, 3) != 0);
                ps_dm_wrb = 1'($urandom);
                dg_dm_add = 16'($urandom); bc_dt_out = 16'($urandom);
            end
            drive_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++; $display("FAIL random cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
        dma_start = 1'b0; ps_dm_cslt = 1'b0;
        checks++;
        if (m_left != 0 || m_done) begin
            failures++; $display("FAIL random_drain left=%0d want 0", m_left);
        end
    endtask

    initial begin
        test_reset();
        test_dma_write();
        test_dma_read();
        test_starvation();
        test_alternate();
        test_zero_len();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
